// File: rtl/mem_arbiter_pkg.sv
// Shared codes for the unified memory arbiter: load/store size encodings and
// the owner state used to sequence responses.
package mem_arbiter_pkg;

    localparam logic [2:0] F3_LSB = 3'b000;
    localparam logic [2:0] F3_LSH = 3'b001;
    localparam logic [2:0] F3_LSW = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_INST = 2'd1,
        ARB_DATA = 2'd2
    } arb_owner_e;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory-side signals around the
// arbiter; slave is the arbiter's view, master the core/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_func3;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [2:0]        mem_func3;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_read, mem_write, mem_func3, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_read, mem_write, mem_func3, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Fetch starvation counter: counts consecutive denied fetch cycles, saturating
// at LIMIT, and flags when fetch must win the next arbitration.
module mem_arbiter_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT_C)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data-priority grant with a fetch starvation guard,
// direct memory drive, and registered one-cycle response per port.
//
// owner    | meaning
// ARB_IDLE | no access last cycle, no response pending
// ARB_INST | fetch owned the memory last cycle, if_rvalid this cycle
// ARB_DATA | load/store owned the memory last cycle, d_rvalid this cycle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    arb_owner_e        owner;
    logic              starve_hit;
    logic              gnt_inst;
    logic              gnt_data;
    logic              starve_clr;

    logic              mem_read_c;
    logic              mem_write_c;
    logic [2:0]        mem_func3_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // Fetch wins when starved, otherwise only when data is not asking.
    assign gnt_inst   = bus.if_req && (starve_hit || !bus.d_req);
    assign gnt_data   = bus.d_req && !gnt_inst;
    assign starve_clr = !bus.if_req || gnt_inst;

    mem_arbiter_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (starve_clr),
        .inc      (!starve_clr),
        .at_limit (starve_hit)
    );

    always_comb begin
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        mem_func3_c = '0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (gnt_inst) begin
            mem_func3_c = F3_LSW;
            mem_addr_c  = bus.if_addr;
        end else if (gnt_data) begin
            mem_read_c  = !bus.d_we;
            mem_write_c = bus.d_we;
            mem_func3_c = bus.d_func3;
            mem_addr_c  = bus.d_addr;
            if (bus.d_we) begin
                mem_wdata_c = bus.d_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= ARB_IDLE;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (gnt_inst) begin
                owner      <= ARB_INST;
                if_rdata_q <= bus.mem_rdata;
            end else if (gnt_data) begin
                owner     <= ARB_DATA;
                // A store acknowledges with zero data rather than stale memory output.
                d_rdata_q <= bus.d_we ? '0 : bus.mem_rdata;
            end else begin
                owner <= ARB_IDLE;
            end
        end
    end

    assign bus.if_gnt    = gnt_inst;
    assign bus.d_gnt     = gnt_data;
    assign bus.if_rvalid = (owner == ARB_INST);
    assign bus.d_rvalid  = (owner == ARB_DATA);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    assign bus.mem_read  = mem_read_c;
    assign bus.mem_write = mem_write_c;
    assign bus.mem_func3 = mem_func3_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide model of the unified memory.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam logic [1:0] G_N = 2'd0;
    localparam logic [1:0] G_I = 2'd1;
    localparam logic [1:0] G_D = 2'd2;

    typedef struct {
        logic        if_req;
        logic [7:0]  if_addr;
        logic        d_req;
        logic        d_we;
        logic [2:0]  f3;
        logic [7:0]  d_addr;
        logic [31:0] d_wdata;
        logic [1:0]  exp_gnt;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W       (8),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Memory model: combinational formatted read, store commits on the falling edge.
    logic [7:0] mem [0:255];
    logic       mem_init = 1'b0;
    logic [7:0] ra;
    logic [7:0] b0, b1, b2, b3;

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
            mem[4] <= 8'h13;
            mem[5] <= 8'h00;
            mem[6] <= 8'h00;
            mem[7] <= 8'h93;
            mem_init <= 1'b1;
        end else if (bus.mem_write) begin
            case (bus.mem_func3)
                F3_LSB: mem[bus.mem_addr] <= bus.mem_wdata[7:0];
                F3_LSH: begin
                    mem[bus.mem_addr]        <= bus.mem_wdata[7:0];
                    mem[bus.mem_addr + 8'd1] <= bus.mem_wdata[15:8];
                end
                F3_LSW: begin
                    mem[bus.mem_addr]        <= bus.mem_wdata[7:0];
                    mem[bus.mem_addr + 8'd1] <= bus.mem_wdata[15:8];
                    mem[bus.mem_addr + 8'd2] <= bus.mem_wdata[23:16];
                    mem[bus.mem_addr + 8'd3] <= bus.mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ra = bus.mem_addr;
        b0 = mem[ra];
        b1 = mem[ra + 8'd1];
        b2 = mem[ra + 8'd2];
        b3 = mem[ra + 8'd3];
        case (bus.mem_func3)
            F3_LSB:  bus.mem_rdata = {{24{b0[7]}}, b0};
            F3_LSH:  bus.mem_rdata = {{16{b1[7]}}, b1, b0};
            F3_LSW:  bus.mem_rdata = {b3, b2, b1, b0};
            F3_LBU:  bus.mem_rdata = {24'h0, b0};
            F3_LHU:  bus.mem_rdata = {16'h0, b1, b0};
            default: bus.mem_rdata = 32'h0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        bus.if_req  = 1'b0;
        bus.if_addr = 8'h00;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_func3 = 3'b000;
        bus.d_addr  = 8'h00;
        bus.d_wdata = 32'h0;
    endtask

    function automatic vec_t mk(input logic ir, input logic [7:0] ia, input logic dr,
                                input logic we, input logic [2:0] f3, input logic [7:0] da,
                                input logic [31:0] wd, input logic [1:0] eg,
                                input logic [31:0] ed, input string nm);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = we; v.f3 = f3;
        v.d_addr = da; v.d_wdata = wd; v.exp_gnt = eg; v.exp_rdata = ed; v.name = nm;
        return v;
    endfunction

    vec_t        vecs [16];
    logic [31:0] last_i, last_d;
    logic        e_rd, e_wr;
    logic [2:0]  e_f3;
    logic [7:0]  e_addr;
    logic [31:0] e_wd;
    logic [1:0]  e_pair;

    initial begin
        vecs[0]  = mk(1, 8'h04, 0, 0, F3_LSW, 8'h00, 32'h0,        G_I, 32'h93000013, "fetch04");
        vecs[1]  = mk(0, 8'h00, 1, 1, F3_LSW, 8'h10, 32'hDEADBEEF, G_D, 32'h00000000, "sw10");
        vecs[2]  = mk(0, 8'h00, 1, 0, F3_LSB, 8'h10, 32'h0,        G_D, 32'hFFFFFFEF, "lb10");
        vecs[3]  = mk(0, 8'h00, 1, 0, F3_LBU, 8'h11, 32'h0,        G_D, 32'h000000BE, "lbu11");
        vecs[4]  = mk(0, 8'h00, 1, 0, F3_LSH, 8'h12, 32'h0,        G_D, 32'hFFFFDEAD, "lh12");
        vecs[5]  = mk(0, 8'h00, 1, 0, F3_LHU, 8'h12, 32'h0,        G_D, 32'h0000DEAD, "lhu12");
        vecs[6]  = mk(1, 8'h04, 1, 0, F3_LSW, 8'h10, 32'h0,        G_D, 32'hDEADBEEF, "both_lw10");
        vecs[7]  = mk(0, 8'h00, 1, 1, F3_LSB, 8'h20, 32'h123456A5, G_D, 32'h00000000, "sb20");
        vecs[8]  = mk(0, 8'h00, 1, 0, F3_LSW, 8'h20, 32'h0,        G_D, 32'h000000A5, "lw20");
        vecs[9]  = mk(0, 8'h00, 1, 0, 3'b011, 8'h10, 32'h0,        G_D, 32'h00000000, "ld_f3_011");
        vecs[10] = mk(0, 8'h00, 1, 1, 3'b111, 8'h10, 32'h55555555, G_D, 32'h00000000, "st_f3_111");
        vecs[11] = mk(0, 8'h00, 1, 0, F3_LSW, 8'h10, 32'h0,        G_D, 32'hDEADBEEF, "lw10_again");
        vecs[12] = mk(1, 8'h10, 0, 0, F3_LSW, 8'h00, 32'h0,        G_I, 32'hDEADBEEF, "fetch10");
        vecs[13] = mk(0, 8'h00, 0, 0, F3_LSW, 8'h00, 32'h0,        G_N, 32'h00000000, "idle");
        vecs[14] = mk(0, 8'h00, 1, 1, F3_LSH, 8'h22, 32'h0000CAFE, G_D, 32'h00000000, "sh22");
        vecs[15] = mk(1, 8'h20, 0, 0, F3_LSW, 8'h00, 32'h0,        G_I, 32'hCAFE00A5, "fetch20");

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("rst d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("rst if_rdata", bus.if_rdata, 32'h0);
        chk("rst d_rdata", bus.d_rdata, 32'h0);
        chk("rst mem_read", 32'(bus.mem_read), 32'h0);
        chk("rst mem_write", 32'(bus.mem_write), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'h0);

        // Table-driven single accesses, issued back-to-back
        last_i = 32'h0;
        last_d = 32'h0;
        for (int i = 0; i < 16; i++) begin
            bus.if_req  = vecs[i].if_req;
            bus.if_addr = vecs[i].if_addr;
            bus.d_req   = vecs[i].d_req;
            bus.d_we    = vecs[i].d_we;
            bus.d_func3 = vecs[i].f3;
            bus.d_addr  = vecs[i].d_addr;
            bus.d_wdata = vecs[i].d_wdata;
            #1;
            e_rd = 1'b0; e_wr = 1'b0; e_f3 = 3'b000; e_addr = 8'h00; e_wd = 32'h0;
            if (vecs[i].exp_gnt == G_I) begin
                e_f3   = F3_LSW;
                e_addr = vecs[i].if_addr;
            end else if (vecs[i].exp_gnt == G_D) begin
                e_rd   = !vecs[i].d_we;
                e_wr   = vecs[i].d_we;
                e_f3   = vecs[i].f3;
                e_addr = vecs[i].d_addr;
                e_wd   = vecs[i].d_we ? vecs[i].d_wdata : 32'h0;
            end
            chk($sformatf("%s if_gnt", vecs[i].name), 32'(bus.if_gnt), 32'(vecs[i].exp_gnt == G_I));
            chk($sformatf("%s d_gnt", vecs[i].name), 32'(bus.d_gnt), 32'(vecs[i].exp_gnt == G_D));
            chk($sformatf("%s mem_read", vecs[i].name), 32'(bus.mem_read), 32'(e_rd));
            chk($sformatf("%s mem_write", vecs[i].name), 32'(bus.mem_write), 32'(e_wr));
            chk($sformatf("%s mem_func3", vecs[i].name), 32'(bus.mem_func3), 32'(e_f3));
            chk($sformatf("%s mem_addr", vecs[i].name), 32'(bus.mem_addr), 32'(e_addr));
            if (e_wr || (vecs[i].exp_gnt == G_N))
                chk($sformatf("%s mem_wdata", vecs[i].name), bus.mem_wdata, e_wd);
            @(posedge clk);
            #1;
            idle_inputs();
            chk($sformatf("%s if_rvalid", vecs[i].name), 32'(bus.if_rvalid), 32'(vecs[i].exp_gnt == G_I));
            chk($sformatf("%s d_rvalid", vecs[i].name), 32'(bus.d_rvalid), 32'(vecs[i].exp_gnt == G_D));
            if (vecs[i].exp_gnt == G_I) last_i = vecs[i].exp_rdata;
            if (vecs[i].exp_gnt == G_D) last_d = vecs[i].exp_rdata;
            chk($sformatf("%s if_rdata", vecs[i].name), bus.if_rdata, last_i);
            chk($sformatf("%s d_rdata", vecs[i].name), bus.d_rdata, last_d);
        end

        // Contention: both held, pattern D,D,D,D,I repeating
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h04;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_func3 = F3_LSW;
        bus.d_addr  = 8'h10;
        for (int c = 0; c < 14; c++) begin
            #1;
            e_pair = ((c % 5) == 4) ? 2'b10 : 2'b01;
            chk($sformatf("contend c%0d {if_gnt,d_gnt}", c), 32'({bus.if_gnt, bus.d_gnt}), 32'(e_pair));
            if (c > 0)
                chk($sformatf("contend c%0d if_rvalid", c), 32'(bus.if_rvalid), 32'(((c - 1) % 5) == 4));
            @(posedge clk);
            #1;
        end

        // Withdrawal: one-cycle store request while fetch holds the override
        bus.d_we    = 1'b1;
        bus.d_addr  = 8'h30;
        bus.d_wdata = 32'h11111111;
        #1;
        chk("withdraw if_gnt", 32'(bus.if_gnt), 32'h1);
        chk("withdraw d_gnt", 32'(bus.d_gnt), 32'h0);
        chk("withdraw mem_write", 32'(bus.mem_write), 32'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("withdraw d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("withdraw if_rvalid", 32'(bus.if_rvalid), 32'h1);
        @(posedge clk);
        #1;
        bus.d_req   = 1'b1;
        bus.d_func3 = F3_LSW;
        bus.d_addr  = 8'h30;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("withdraw lw30 d_rvalid", 32'(bus.d_rvalid), 32'h1);
        chk("withdraw lw30 d_rdata", bus.d_rdata, 32'h0);

        // Mid-run reset kills an in-flight response
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h04;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("pre_rst if_rvalid", 32'(bus.if_rvalid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("midrst if_rdata", bus.if_rdata, 32'h0);
        chk("midrst d_rvalid", 32'(bus.d_rvalid), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_rel rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'h0);

        // Release while a fetch is pending: arbitration resumes at the next edge
        rst_n       = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h04;
        @(posedge clk);
        #1;
        chk("in_rst if_rvalid", 32'(bus.if_rvalid), 32'h0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("resume if_rvalid", 32'(bus.if_rvalid), 32'h1);
        chk("resume if_rdata", bus.if_rdata, 32'h93000013);
        @(posedge clk);
        #1;
        chk("resume pulse end", 32'(bus.if_rvalid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
